// File: rtl/time_counter_module_pkg.sv
// ---------------------------------------------------------------------------
// time_counter_module_pkg
//
// Purpose:
//    Shared constants and types for the time-of-day counter and its
//    neighbours. The AM/PM decoder imports HOUR_NOON and is_pm() from here, so
//    the noon boundary is defined in exactly one place.
//
// Contents:
//    TIME_W                      width of every time field (sec/min/hour)
//    SEC_MOD, MIN_MOD, HOUR_MOD  field moduli
//    HOUR_NOON                   first PM hour
//    time_fields_t               packed bundle of the three fields
//    is_pm()                     AM/PM classification of a 24-hour value
// ---------------------------------------------------------------------------
package time_counter_module_pkg;

   localparam int TIME_W    = 6;
   localparam int SEC_MOD   = 60;
   localparam int MIN_MOD   = 60;
   localparam int HOUR_MOD  = 24;
   localparam int HOUR_NOON = 12;

   typedef struct packed {
      logic [TIME_W-1:0] hour;
      logic [TIME_W-1:0] min;
      logic [TIME_W-1:0] sec;
   } time_fields_t;

   // Hours 12..23 are PM in 24-hour format.
   function automatic logic is_pm(input logic [TIME_W-1:0] hour);
      return (hour >= TIME_W'(HOUR_NOON));
   endfunction

endpackage : time_counter_module_pkg

// File: rtl/time_counter_module_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//
// Purpose:
//    Registered modulo-MOD counter used for the seconds, minutes and hours
//    fields. Counts 0..MOD-1 and wraps to 0.
//
// Ports:
//    clk    in   system clock, posedge
//    reset  in   asynchronous active-low reset, clears value
//    inc    in   advance value by one (mod MOD) on the next edge
//    clr    in   force value to zero on the next edge; wins over inc
//    value  out  registered count, 0..MOD-1
//    carry  out  combinational: inc is asserted while value is MOD-1, so the
//                next edge wraps; used to chain the next field
// ---------------------------------------------------------------------------
module mod_counter
   import time_counter_module_pkg::*;
#(
   parameter int MOD = 60,
   parameter int W   = TIME_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         carry
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;
   logic         at_last;

   // Next-value logic: clear has priority, otherwise increment with wrap.
   always_comb begin
      value_d = value_q;
      at_last = (value_q == LAST);
      if (clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = at_last ? '0 : value_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc && at_last;

endmodule : mod_counter

// File: rtl/time_counter_module.sv
// ---------------------------------------------------------------------------
// time_counter_module
//
// Purpose:
//    Real-time-of-day counter for the board clock display. Divides the system
//    clock down to a 1 Hz strobe and keeps seconds, minutes and hours in
//    24-hour format. With run_en low the time is held and can be adjusted by
//    debounced single-cycle button pulses.
//
// Ports:
//    clk       in   system clock, posedge
//    reset     in   asynchronous active-low reset
//    run_en    in   1 = time runs, 0 = hold/set mode
//    inc_min   in   pulse, minute +1 (no carry), set mode only
//    inc_hour  in   pulse, hour +1, set mode only
//    clr_sec   in   pulse, clear seconds and prescaler, set mode only
//    sec       out  seconds 0..59 (registered)
//    min       out  minutes 0..59 (registered)
//    hour      out  hours 0..23 (registered), feeds the AM/PM decoder as-is
//    tick_1hz  out  one-cycle pulse, valid together with the updated time
// ---------------------------------------------------------------------------
module time_counter_module
   import time_counter_module_pkg::*;
#(
   parameter int CLK_HZ = 50000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_en,
   input  logic              inc_min,
   input  logic              inc_hour,
   input  logic              clr_sec,
   output logic [TIME_W-1:0] sec,
   output logic [TIME_W-1:0] min,
   output logic [TIME_W-1:0] hour,
   output logic              tick_1hz
);

   // A 1-bit counter is still needed when CLK_HZ==1 ($clog2(1)==0).
   localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic             tick_1hz_q;
   logic             tick_1hz_d;
   logic             strobe;
   logic             set_mode;

   logic             sec_inc;
   logic             sec_clr;
   logic             sec_carry;
   logic             min_inc;
   logic             min_carry;
   logic             hour_inc;
   logic             hour_carry;

   // Prescaler. Held at zero outside run mode, so the first strobe after
   // run_en rises lands exactly CLK_HZ edges later. clr_sec only acts in set
   // mode, where the counter is already being forced to zero.
   always_comb begin
      set_mode   = !run_en;
      strobe     = run_en && (div_cnt_q == DIV_LAST);
      div_cnt_d  = div_cnt_q + 1'b1;
      if (set_mode || strobe) begin
         div_cnt_d = '0;
      end
      tick_1hz_d = strobe;
   end

   // Field enables. Strobe and button pulses are mutually exclusive by
   // run_en, so each enable is a simple OR of the two sources. The hour only
   // takes the minute carry on a running strobe; an inc_min wrap in set mode
   // must not touch the hour even though min_carry fires then too.
   always_comb begin
      sec_inc  = strobe;
      sec_clr  = set_mode && clr_sec;
      min_inc  = (strobe && sec_carry) || (set_mode && inc_min);
      hour_inc = (strobe && sec_carry && min_carry) || (set_mode && inc_hour);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q  <= '0;
         tick_1hz_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         tick_1hz_q <= tick_1hz_d;
      end
   end

   mod_counter #(.MOD(SEC_MOD), .W(TIME_W)) u_sec (
      .clk   (clk),
      .reset (reset),
      .inc   (sec_inc),
      .clr   (sec_clr),
      .value (sec),
      .carry (sec_carry)
   );

   mod_counter #(.MOD(MIN_MOD), .W(TIME_W)) u_min (
      .clk   (clk),
      .reset (reset),
      .inc   (min_inc),
      .clr   (1'b0),
      .value (min),
      .carry (min_carry)
   );

   mod_counter #(.MOD(HOUR_MOD), .W(TIME_W)) u_hour (
      .clk   (clk),
      .reset (reset),
      .inc   (hour_inc),
      .clr   (1'b0),
      .value (hour),
      .carry (hour_carry)
   );

   assign tick_1hz = tick_1hz_q;

   // Range invariants on every cycle out of reset.
   a_sec_range: assert property (@(posedge clk) disable iff (!reset)
      sec < TIME_W'(SEC_MOD));
   a_min_range: assert property (@(posedge clk) disable iff (!reset)
      min < TIME_W'(MIN_MOD));
   a_hour_range: assert property (@(posedge clk) disable iff (!reset)
      hour < TIME_W'(HOUR_MOD));

   // The tick is a single-cycle pulse unless the prescaler divides by one.
   a_tick_single: assert property (@(posedge clk) disable iff (!reset)
      tick_1hz |=> (!tick_1hz || (CLK_HZ == 1)));

   // Any hour wrap, running or set, must land on hour zero.
   a_hour_wrap: assert property (@(posedge clk) disable iff (!reset)
      hour_carry |=> (hour == '0));

endmodule : time_counter_module

// File: tb/tb_time_counter_module.sv
// ---------------------------------------------------------------------------
// tb_time_counter_module
//
// Bench for time_counter_module with CLK_HZ=4. The reference keeps the time
// as a single seconds-of-day integer plus a cycle phase counter; button
// actions decompose that integer into h/m/s, adjust and recombine it.
// ---------------------------------------------------------------------------
module tb_time_counter_module;

   localparam int CLK_HZ = 4;
   localparam int DAY    = 24 * 3600;

   logic       clk;
   logic       reset;
   logic       run_en;
   logic       inc_min;
   logic       inc_hour;
   logic       clr_sec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [5:0] hour;
   logic       tick_1hz;

   int errorCount = 0;
   int checkCount = 0;

   // Reference state.
   int refTime  = 0;
   int refPhase = 0;
   int refTick  = 0;

   time_counter_module #(.CLK_HZ(CLK_HZ)) dut (
      .clk      (clk),
      .reset    (reset),
      .run_en   (run_en),
      .inc_min  (inc_min),
      .inc_hour (inc_hour),
      .clr_sec  (clr_sec),
      .sec      (sec),
      .min      (min),
      .hour     (hour),
      .tick_1hz (tick_1hz)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Compare all outputs against the reference.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".sec"},  int'(sec),      refTime % 60);
      checkOutput({tag, ".min"},  int'(min),      (refTime / 60) % 60);
      checkOutput({tag, ".hour"}, int'(hour),     refTime / 3600);
      checkOutput({tag, ".tick"}, int'(tick_1hz), refTick);
   endtask

   task automatic modelReset();
      refTime  = 0;
      refPhase = 0;
      refTick  = 0;
   endtask

   // Advance the reference by one clock edge with the given inputs.
   task automatic modelEdge(input bit run, input bit im, input bit ih, input bit cs);
      int h, m, s;
      refTick = 0;
      if (run) begin
         refPhase++;
         if (refPhase == CLK_HZ) begin
            refPhase = 0;
            refTime  = (refTime + 1) % DAY;
            refTick  = 1;
         end
      end else begin
         refPhase = 0;
         h = refTime / 3600;
         m = (refTime / 60) % 60;
         s = refTime % 60;
         if (cs) s = 0;
         if (im) m = (m + 1) % 60;
         if (ih) h = (h + 1) % 24;
         refTime = h * 3600 + m * 60 + s;
      end
   endtask

   // Drive one cycle of inputs, clock it, update the reference, check #1 later.
   task automatic applyStimulus(input bit run, input bit im, input bit ih, input bit cs,
                                input string tag);
      run_en   = run;
      inc_min  = im;
      inc_hour = ih;
      clr_sec  = cs;
      @(posedge clk);
      modelEdge(run, im, ih, cs);
      #1;
      checkAll(tag);
   endtask

   initial begin
      reset    = 1'b0;
      run_en   = 1'b0;
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      clr_sec  = 1'b0;
      modelReset();

      // Reset state.
      #12;
      checkAll("reset");

      // Release reset running; ticks on cycles 4, 8, ...
      reset  = 1'b1;
      run_en = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         applyStimulus(1, 0, 0, 0, "run");
         checkOutput("tick_cycle", int'(tick_1hz), (c % 4 == 0) ? 1 : 0);
      end
      checkOutput("sec_after6", int'(sec), 1);

      // Asynchronous reset mid-count, checked before the next edge.
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkAll("async_reset");
      #2;
      reset = 1'b1;

      // Set 23:59:00 then run up to midnight.
      for (int i = 0; i < 23; i++) applyStimulus(0, 0, 1, 0, "set_hour");
      for (int i = 0; i < 59; i++) applyStimulus(0, 1, 0, 0, "set_min");
      applyStimulus(0, 0, 0, 1, "clr_sec");
      for (int i = 0; i < 59 * CLK_HZ; i++) applyStimulus(1, 0, 0, 0, "to_2359");
      checkOutput("pre_wrap_sec",  int'(sec),  59);
      checkOutput("pre_wrap_min",  int'(min),  59);
      checkOutput("pre_wrap_hour", int'(hour), 23);
      for (int i = 0; i < CLK_HZ; i++) applyStimulus(1, 0, 0, 0, "midnight");
      checkOutput("wrap_sec",  int'(sec),      0);
      checkOutput("wrap_min",  int'(min),      0);
      checkOutput("wrap_hour", int'(hour),     0);
      checkOutput("wrap_tick", int'(tick_1hz), 1);

      // From 05:58, three inc_min pulses wrap minutes without carrying.
      for (int i = 0; i < 5; i++)  applyStimulus(0, 0, 1, 0, "set5h");
      for (int i = 0; i < 58; i++) applyStimulus(0, 1, 0, 0, "set58m");
      for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, "min_wrap");
      checkOutput("nocarry_min",  int'(min),  1);
      checkOutput("nocarry_hour", int'(hour), 5);

      // Hour to 0, then through noon and back round.
      for (int i = 0; i < 19; i++) applyStimulus(0, 0, 1, 0, "hour_to0");
      checkOutput("hour_zero", int'(hour), 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, "to_noon");
      checkOutput("hour_noon", int'(hour), 12);
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, "past_noon");
      checkOutput("hour_wrap", int'(hour), 0);

      // Simultaneous pulses in set mode, then ignored in run mode.
      applyStimulus(0, 1, 1, 0, "both_set");
      checkOutput("both_min",  int'(min),  2);
      checkOutput("both_hour", int'(hour), 1);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1, "pulses_run");
      checkOutput("run_ign_min",  int'(min),  2);
      checkOutput("run_ign_hour", int'(hour), 1);

      // Enable to div_cnt=2, hold three cycles, re-enable: tick 4 cycles later.
      applyStimulus(0, 0, 0, 0, "align");
      applyStimulus(1, 0, 0, 0, "pre_hold");
      applyStimulus(1, 0, 0, 0, "pre_hold");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "hold");
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, 0, 0, 0, "reenable");
         checkOutput("reenable_tick", int'(tick_1hz), (i == 4) ? 1 : 0);
      end

      // Randomised mix of run/hold and button pulses.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 5) == 0,
                       "random");
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule : tb_time_counter_module

// File: doc/time_counter_module.md
Name: time_counter_module

Overview:
- Real-time-of-day counter for the board clock display: divides the system clock to a 1 Hz tick and keeps seconds, minutes and hours in 24-hour format.
- Sits directly upstream of the AM/PM decoder and the 7-segment/LCD display drivers. Its hour output (0..23, 6 bits) feeds the AM/PM decoder unchanged.
- Provides a hold/set mode so the user's debounced buttons can adjust the time.

Parameters:
- CLK_HZ, 50000000, system clock frequency. Also the prescaler modulus. Benches override it to 4.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- run_en  in  1  1 = time runs; 0 = hold/set mode
- inc_min  in  1  single-cycle pulse, minute +1; honoured only when run_en=0
- inc_hour  in  1  single-cycle pulse, hour +1; honoured only when run_en=0
- clr_sec  in  1  single-cycle pulse, seconds and prescaler cleared; honoured only when run_en=0
- sec  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hour  out  6  hours, 0..23
- tick_1hz  out  1  one-cycle pulse, coincident with each running seconds update

Behaviour:
- Reset (reset=0, asynchronous):
  - div_cnt=0, sec=0, min=0, hour=0, tick_1hz=0.
  - Takes effect immediately, even mid-count or mid-set.
- Prescaler:
  - div_cnt counts 0..CLK_HZ-1 while run_en=1.
  - The internal strobe is active when div_cnt==CLK_HZ-1 and run_en=1. On that edge div_cnt wraps to 0.
  - While run_en=0, div_cnt is forced to 0 and no strobe occurs.
  - After run_en rises, the first tick comes exactly CLK_HZ cycles later.
- tick_1hz:
  - Registered; high for exactly the one cycle after a strobe edge.
  - The new sec/min/hour values become visible on that same edge, so they are valid together with tick_1hz.
- Running count (on strobe):
  - sec increments.
  - sec 59→0 carries into min. min 59→0 carries into hour. hour 23→0.
  - 23:59:59 → 00:00:00 in one edge, with no intermediate value.
- Set mode (run_en=0):
  - inc_min: min = (min+1) mod 60. No carry into hour; sec untouched.
  - inc_hour: hour = (hour+1) mod 24; min and sec untouched.
  - clr_sec: sec=0, div_cnt=0.
  - Any combination of inc_min, inc_hour and clr_sec in the same cycle: all are applied independently.
- While run_en=1, inc_min, inc_hour and clr_sec are ignored entirely.
- If run_en falls on a strobe cycle, the strobe still completes; hold mode starts on the next cycle.
- Pulse width: each pulse cycle counts as one increment. Callers supply edge-detected, debounced pulses.
- Invariants, checked by assertion: sec<60, min<60, hour<24 on every cycle. tick_1hz is never high on two consecutive cycles unless CLK_HZ==1.
- Latency: one clock from input pulse or strobe to the updated output. No combinational paths from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - TIME_W=6
  - SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24
  - the HOUR_NOON=12 boundary, shared with the AM/PM decoder
- One natural sub-module, mod_counter:
  - parameter MOD
  - inputs: inc, clr
  - outputs: value, carry (carry = inc && value==MOD-1)
  - instantiated three times: sec, min, hour.
- The prescaler stays inline.

Test Plan (CLK_HZ=4):
- Release reset with run_en=1: tick_1hz pulses on cycles 4, 8, 12…; sec reads 1, 2, 3 on the matching cycles. Assert reset mid-count at cycle 6 → all outputs 0 immediately, before the next clk edge.
- run_en=0; set the time with inc_hour ×23, inc_min ×59, then clr_sec. Run 59 ticks to reach 23:59:59. One more tick → 00:00:00 with tick_1hz=1 on the same cycle.
- run_en=0, from min=58, hour=5: 3 inc_min pulses → min=1, hour stays 5 (no carry).
- run_en=0, from hour=0: 12 inc_hour pulses → hour=12 (downstream AM/PM decoder reports PM). 12 more → hour=0.
- Same-cycle inc_min+inc_hour in set mode → both fields +1. The same pulses with run_en=1 → no change except normal ticking.
- Toggle run_en 1→0 at div_cnt=2, then back to 1 → next tick exactly 4 cycles after re-enable; sec unchanged during hold.
